// File: rtl/esc_pkg.sv
// rtl/esc_pkg.sv - shared state encoding and constants for the ESC PWM decoder
package esc_pkg;

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2
  } esc_state_e;

  localparam int ESC_BASE_CNT    = 50000;
  localparam int ESC_SHIFT       = 4;
  localparam int ESC_PERIOD_W    = 18;
  localparam int ESC_VALUE_W     = 12;
  localparam int ESC_HCNT_W      = 17;
  localparam int ESC_TO_W        = 20;
  localparam int ESC_TIMEOUT_CNT = 524288;

endpackage

// File: rtl/esc_in_sync.sv
// rtl/esc_in_sync.sv - PWM input synchronizer, optional stability filter (ESC_DEC_GLITCH_FILTER_EN), edge pulses
module esc_in_sync (
  input  logic clk,
  input  logic rst,
  input  logic pwm_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // Synchronizer and level state reset high so that a pin already high
  // after reset produces no rising edge; a real low must be seen first.
  logic s1_q, s2_q;
  logic level_q, rise_q, fall_q;
  logic accept;

`ifdef ESC_DEC_GLITCH_FILTER_EN
  logic s3_q, s4_q;

  // A new level is taken only once three consecutive synchronized samples agree.
  always_comb accept = (s2_q == s3_q) && (s3_q == s4_q) && (s2_q != level_q);

  // History of the synchronized level feeding the stability check.
  always_ff @(posedge clk) begin
    if (rst) begin
      s3_q <= 1'b1;
      s4_q <= 1'b1;
    end else begin
      s3_q <= s2_q;
      s4_q <= s3_q;
    end
  end
`else
  // Every synchronized transition is taken as an edge.
  always_comb accept = (s2_q != level_q);
`endif

  // Two-flop synchronizer, accepted level and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b1;
      s2_q    <= 1'b1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      s1_q    <= pwm_i;
      s2_q    <= s1_q;
      level_q <= accept ? s2_q : level_q;
      rise_q  <= accept & s2_q;
      fall_q  <= accept & ~s2_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/esc_pwm_decoder.sv
// rtl/esc_pwm_decoder.sv - ESC PWM high-time decoder; input filter selected by ESC_DEC_GLITCH_FILTER_EN
module esc_pwm_decoder
  import esc_pkg::*;
#(
  parameter int BASE_CNT    = ESC_BASE_CNT,
  parameter int SHIFT       = ESC_SHIFT,
  parameter int TIMEOUT_CNT = ESC_TIMEOUT_CNT,
  parameter int HCNT_W      = ESC_HCNT_W,
  parameter int TO_W        = ESC_TO_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PWM_in,
  output logic [ESC_VALUE_W-1:0] VALUE,
  output logic                   vld,
  output logic                   err,
  output logic                   lost
);

  localparam int D_W = HCNT_W + 1;
  localparam logic [D_W-1:0] VMAX = D_W'((1 << ESC_VALUE_W) - 1);

  logic level, rise, fall;

  esc_in_sync u_in_sync (
    .clk     (clk),
    .rst     (rst),
    .pwm_i   (PWM_in),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  esc_state_e             state_q, state_d;
  logic [HCNT_W-1:0]      hcnt_q, hcnt_d;
  logic                   ovf_q, ovf_d;
  logic [TO_W-1:0]        tcnt_q, tcnt_d;
  logic [ESC_VALUE_W-1:0] value_q, value_d;
  logic                   vld_q, vld_d;
  logic                   err_q, err_d;
  logic                   lost_q, lost_d;

  // d = H - BASE - 1 in signed arithmetic; the sign bit marks an underrange pulse.
  logic signed [D_W-1:0] diff;
  logic [D_W-1:0]        quo;
  logic                  pulse_ok;
  logic                  timeout;

  assign diff     = $signed({1'b0, hcnt_q}) - $signed(D_W'(BASE_CNT + 1));
  assign quo      = $unsigned(diff) >> SHIFT;
  assign pulse_ok = !diff[D_W-1] && !ovf_q && (quo <= VMAX);
  assign timeout  = !rise && (tcnt_q == TO_W'(TIMEOUT_CNT - 1));

  // Next-state: frame FSM, width measurement, evaluation and loss-of-signal.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    ovf_d   = ovf_q;
    value_d = value_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    lost_d  = lost_q;
    tcnt_d  = rise ? '0 : ((&tcnt_q) ? tcnt_q : tcnt_q + 1'b1);

    case (state_q)
      SYNC: begin
        if (!level) state_d = WAIT_RISE;
      end
      WAIT_RISE: begin
        if (rise) begin
          hcnt_d  = HCNT_W'(1);
          ovf_d   = 1'b0;
          state_d = MEAS_HIGH;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          state_d = WAIT_RISE;
          if (pulse_ok) begin
            value_d = quo[ESC_VALUE_W-1:0];
            vld_d   = 1'b1;
            lost_d  = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end else if (&hcnt_q) begin
          ovf_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    // Loss of signal overrides any evaluation in the same cycle.
    if (timeout) begin
      state_d = SYNC;
      value_d = '0;
      vld_d   = 1'b0;
      err_d   = 1'b0;
      lost_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SYNC;
      hcnt_q  <= '0;
      ovf_q   <= 1'b0;
      tcnt_q  <= '0;
      value_q <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      ovf_q   <= ovf_d;
      tcnt_q  <= tcnt_d;
      value_q <= value_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign VALUE = value_q;
  assign vld   = vld_q;
  assign err   = err_q;
  assign lost  = lost_q;

endmodule

// File: tb/tb_esc_pwm_decoder.sv
// tb/tb_esc_pwm_decoder.sv - scoreboard bench for esc_pwm_decoder (scaled timing parameters)
module tb_esc_pwm_decoder;

  localparam int BASE = 100;
  localparam int SH   = 1;
  localparam int TMO  = 20000;
  localparam int HW   = 14;
`ifdef ESC_DEC_GLITCH_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 4;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm = 1'b0;
  logic [11:0] value;
  logic        vld, err, lost;

  esc_pwm_decoder #(
    .BASE_CNT    (BASE),
    .SHIFT       (SH),
    .TIMEOUT_CNT (TMO),
    .HCNT_W      (HW),
    .TO_W        (20)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .PWM_in (pwm),
    .VALUE  (value),
    .vld    (vld),
    .err    (err),
    .lost   (lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int val;
    int due;
  } exp_t;

  typedef struct {
    int h;
    bit is_err;
    int val;
  } vec_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // H -> expected result with BASE=100, SHIFT=1: d = H-101, VALUE = d>>1, err keeps last VALUE
  vec_t vecs[9] = '{
    '{101,  1'b0, 0},
    '{2102, 1'b0, 1000},
    '{8291, 1'b0, 4095},
    '{8292, 1'b0, 4095},
    '{8293, 1'b1, 4095},
    '{100,  1'b1, 4095},
    '{102,  1'b0, 0},
    '{90,   1'b1, 0},
    '{2102, 1'b0, 1000}
  };

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input bit is_err, input int val, input int due);
    exp_t e;
    e.is_err = is_err;
    e.val    = val;
    e.due    = due;
    sbq.push_back(e);
  endtask

  task automatic pulse(input int h, input int low, input bit expect_out,
                       input bit is_err, input int val, output int t_rise);
    @(posedge clk);
    #1 pwm = 1'b1;
    t_rise = cyc;
    repeat (h) @(posedge clk);
    #1 pwm = 1'b0;
    if (expect_out) push(is_err, val, cyc + LAT);
    repeat (low) @(posedge clk);
  endtask

  // Monitor: every vld/err pulse is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (vld || err)) begin
      check("vld_err_exclusive", int'(vld & err), 0);
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got vld=%0d err=%0d value=%0d, expected none (cycle %0d)",
                 vld, err, value, cyc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("kind_err", int'(err), int'(e.is_err));
        check("value", int'(value), e.val);
        check("latency", cyc, e.due);
      end
    end
  end

  initial begin
    int t_rise;
    int w;

    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_value", int'(value), 0);
    check("reset_vld", int'(vld), 0);
    check("reset_err", int'(err), 0);
    check("reset_lost", int'(lost), 1);
    repeat (50) @(posedge clk);

    // Table of directed pulses
    for (int i = 0; i < 9; i++) begin
      pulse(vecs[i].h, 200, 1'b1, vecs[i].is_err, vecs[i].val, t_rise);
      if (i == 0) check("lost_clears", int'(lost), 0);
    end

    // Stuck high past counter saturation, then loss of signal
    pulse(17000, 0, 1'b1, 1'b1, 1000, t_rise);
    check("lost_before_timeout", int'(lost), 0);
    w = 0;
    while (!lost && w < 25000) begin
      @(posedge clk);
      #1 w++;
    end
    check("lost_timeout", int'(lost), 1);
    check("timeout_cycle", cyc - t_rise, TMO + 4);
    check("timeout_value", int'(value), 0);
    repeat (100) @(posedge clk);

    pulse(2102, 200, 1'b1, 1'b0, 1000, t_rise);
    check("lost_recovers", int'(lost), 0);

    // Reset during a pulse; input still high when reset releases
    @(posedge clk);
    #1 pwm = 1'b1;
    repeat (1000) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_mid_value", int'(value), 0);
    check("rst_mid_lost", int'(lost), 1);
    repeat (1000) @(posedge clk);
    #1 pwm = 1'b0;
    repeat (200) @(posedge clk);

    pulse(8291, 200, 1'b1, 1'b0, 4095, t_rise);
    check("lost_after_rst", int'(lost), 0);

    // Two-cycle low glitch inside a 2102-cycle high pulse
    @(posedge clk);
    #1 pwm = 1'b1;
    repeat (50) @(posedge clk);
    #1 pwm = 1'b0;
`ifndef ESC_DEC_GLITCH_FILTER_EN
    push(1'b1, 4095, cyc + LAT);
`endif
    repeat (2) @(posedge clk);
    #1 pwm = 1'b1;
    repeat (2050) @(posedge clk);
    #1 pwm = 1'b0;
`ifdef ESC_DEC_GLITCH_FILTER_EN
    push(1'b0, 1000, cyc + LAT);
`else
    push(1'b0, 974, cyc + LAT);
`endif

    w = 0;
    while (sbq.size() != 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    repeat (5) @(posedge clk);
    check("scoreboard_drained", sbq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
